// File: rtl/mdu_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package mdu_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned CntW = $clog2(XLEN);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } mdu_state_e;

    localparam logic [2:0] F3Mul    = 3'b000;
    localparam logic [2:0] F3Mulh   = 3'b001;
    localparam logic [2:0] F3Mulhsu = 3'b010;
    localparam logic [2:0] F3Mulhu  = 3'b011;
    localparam logic [2:0] F3Div    = 3'b100;
    localparam logic [2:0] F3Divu   = 3'b101;
    localparam logic [2:0] F3Rem    = 3'b110;
    localparam logic [2:0] F3Remu   = 3'b111;

    localparam logic [6:0] Funct7MOp = 7'b0000001;

    // Two's-complement negate when neg is set; used for magnitudes and sign fix-up.
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// EX-stage <-> multiply/divide sequencer handshake bundle.
interface mdu_sequencer_if;
    import mdu_pkg::*;

    logic            start;
    logic [2:0]      f3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    // EX stage side: issues the M-op and consumes the result.
    modport master (
        output start, f3, rs1, rs2, flush,
        input  stall, busy, done, result
    );

    // Sequencer side.
    modport slave (
        input  start, f3, rs1, rs2, flush,
        output stall, busy, done, result
    );

endinterface

// File: rtl/mdu_iter_core.sv
// Radix-2 iteration datapath: shift-add multiply or restoring shift-subtract divide.
// hi/lo hold {product high, multiplier/product low} or {remainder, dividend/quotient}.
module mdu_iter_core
    import mdu_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_load,
    input  logic            i_step,
    input  logic            i_is_div,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_hi_nxt,
    output logic [XLEN-1:0] o_lo_nxt
);

    logic [XLEN-1:0] hi_q, lo_q, b_q;
    logic [XLEN-1:0] hi_d, lo_d;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_sh;
    logic [XLEN-1:0] div_diff;
    logic            div_ge;

    // One iteration step; exposed so the last step can be consumed without an extra cycle.
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_sh   = {hi_q, lo_q[XLEN-1]};
        div_ge   = div_sh >= {1'b0, b_q};
        // Low bits are exact whenever div_ge holds, since the remainder stays below b.
        div_diff = div_sh[XLEN-1:0] - b_q;
        if (i_is_div) begin
            hi_d = div_ge ? div_diff : div_sh[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], div_ge};
        end else begin
            hi_d = mul_sum[XLEN:1];
            lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    // Operand load on start, then one step per enabled cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
            b_q  <= '0;
        end else if (i_load) begin
            hi_q <= '0;
            lo_q <= i_a;
            b_q  <= i_b;
        end else if (i_step) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign o_hi_nxt = hi_d;
    assign o_lo_nxt = lo_d;

endmodule

// File: rtl/mdu_sequencer.sv
// RV32M multiply/divide sequencer: FSM, counter, special cases, sign handling.
module mdu_sequencer
    import mdu_pkg::*;
(
    input  logic           i_clk,
    input  logic           i_rst_n,
    mdu_sequencer_if.slave bus
);

    mdu_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      f3_q, f3_d;
    logic            neg_q, neg_d;
    logic            neg_rem_q, neg_rem_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            go, last;
    logic            a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;
    logic [XLEN-1:0] hi_nxt, lo_nxt;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0] mul_res, div_res, calc_res;

    // Decode of the operands presented at start.
    always_comb begin
        a_signed = (bus.f3 == F3Mulh) || (bus.f3 == F3Mulhsu) ||
                   (bus.f3 == F3Div)  || (bus.f3 == F3Rem);
        b_signed = (bus.f3 == F3Mulh) || (bus.f3 == F3Div) || (bus.f3 == F3Rem);
        a_neg    = a_signed & bus.rs1[XLEN-1];
        b_neg    = b_signed & bus.rs2[XLEN-1];
        a_mag    = cond_neg(bus.rs1, a_neg);
        b_mag    = cond_neg(bus.rs2, b_neg);
        div_zero = bus.f3[2] && (bus.rs2 == '0);
        div_ovf  = ((bus.f3 == F3Div) || (bus.f3 == F3Rem)) &&
                   (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2 == '1);
        special  = div_zero | div_ovf;
        // f3[1] selects REM/REMU over DIV/DIVU.
        if (div_zero) begin
            special_res = bus.f3[1] ? bus.rs1 : '1;
        end else begin
            special_res = bus.f3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // Final sign fix-up applied to the result of the last iteration step.
    always_comb begin
        prod     = {hi_nxt, lo_nxt};
        prod_s   = neg_q ? -prod : prod;
        mul_res  = (f3_q == F3Mul) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        div_res  = f3_q[1] ? cond_neg(hi_nxt, neg_rem_q) : cond_neg(lo_nxt, neg_q);
        calc_res = f3_q[2] ? div_res : mul_res;
    end

    assign go   = (state_q == StIdle) && bus.start && !bus.flush;
    assign last = (cnt_q == CntW'(XLEN - 1));

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush wins over everything, start is ignored outside IDLE.
    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (bus.start) state_d = special ? StDone : StCalc;
                StCalc:  if (last)      state_d = StDone;
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Output decode.
    always_comb begin
        bus.stall  = go || (state_q == StCalc);
        bus.busy   = (state_q != StIdle);
        bus.done   = (state_q == StDone);
        bus.result = result_q;
    end

    // Datapath next-state: operand capture, counter, result latch.
    always_comb begin
        cnt_d     = cnt_q;
        f3_d      = f3_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        if (go) begin
            cnt_d     = '0;
            f3_d      = bus.f3;
            neg_d     = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            if (special) result_d = special_res;
        end else if (state_q == StCalc) begin
            cnt_d = cnt_q + CntW'(1);
            if (last && !bus.flush) result_d = calc_res;
        end
    end

    // Datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q     <= '0;
            f3_q      <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            cnt_q     <= cnt_d;
            f3_q      <= f3_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    mdu_iter_core u_core (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (go),
        .i_step   (state_q == StCalc),
        .i_is_div (f3_q[2]),
        .i_a      (a_mag),
        .i_b      (b_mag),
        .o_hi_nxt (hi_nxt),
        .o_lo_nxt (lo_nxt)
    );

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed self-checking bench for mdu_sequencer.
module tb_mdu_sequencer;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    int   done_pulses = 0;
    int   lat, stalls, d0;

    mdu_sequencer_if bus ();

    mdu_sequencer dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.done === 1'b1) done_pulses++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after the start cycle's inputs are driven; measures cycles to done.
    task automatic wait_done(output int l, output int s);
        l = 0;
        s = 0;
        #1;
        while (bus.done !== 1'b1 && l < 40) begin
            if (bus.stall === 1'b1) s++;
            @(negedge clk);
            #1;
            l++;
            if (l == 1 && bus.done !== 1'b1) begin
                bus.rs1 = $urandom;
                bus.rs2 = $urandom;
                bus.f3  = 3'($urandom_range(0, 7));
            end
        end
        if (bus.done !== 1'b1) l = -1;
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat, input string tag);
        int l, s;
        @(negedge clk);
        bus.start = 1'b1;
        bus.f3    = f3;
        bus.rs1   = a;
        bus.rs2   = b;
        wait_done(l, s);
        check({tag, "_result"}, bus.result, exp);
        check({tag, "_latency"}, l, exp_lat);
        check({tag, "_stall_cycles"}, s, exp_lat);
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        check({tag, "_done_after"}, {31'b0, bus.done}, 32'd0);
        check({tag, "_busy_after"}, {31'b0, bus.busy}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.f3    = '0;
        bus.rs1   = '0;
        bus.rs2   = '0;
        bus.flush = 1'b0;
        #2;
        check("reset_busy", {31'b0, bus.busy}, 32'd0);
        check("reset_done", {31'b0, bus.done}, 32'd0);
        check("reset_result", bus.result, 32'd0);
        check("reset_stall", {31'b0, bus.stall}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(F3Mul,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul_neg");
        run_op(F3Mulhu,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu");
        run_op(F3Mulh,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, "mulh");
        run_op(F3Mulhsu, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33, "mulhsu");
        run_op(F3Div,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, "div_neg");
        run_op(F3Rem,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, "rem_neg");
        run_op(F3Divu,   32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 33, "divu");
        run_op(F3Divu,   32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 1,  "divu_by0");
        run_op(F3Rem,    32'd5,         32'd0,         32'd5,         1,  "rem_by0");
        run_op(F3Rem,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  "rem_ovf");
        run_op(F3Div,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  "div_ovf");

        // Flush at counter 10, with start still high to exercise flush priority.
        @(negedge clk);
        bus.start = 1'b1;
        bus.f3    = F3Mul;
        bus.rs1   = 32'd5;
        bus.rs2   = 32'd6;
        d0        = done_pulses;
        repeat (11) @(negedge clk);
        #1;
        check("flush_pre_stall", {31'b0, bus.stall}, 32'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        #1;
        check("flush_busy", {31'b0, bus.busy}, 32'd0);
        check("flush_done", {31'b0, bus.done}, 32'd0);
        check("flush_stall", {31'b0, bus.stall}, 32'd0);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        repeat (40) @(negedge clk);
        check("flush_no_done", done_pulses - d0, 32'd0);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        bus.start = 1'b1;
        bus.f3    = F3Mul;
        bus.rs1   = 32'd9;
        bus.rs2   = 32'd9;
        repeat (6) @(negedge clk);
        #1;
        check("rst_pre_busy", {31'b0, bus.busy}, 32'd1);
        bus.start = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_stall", {31'b0, bus.stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(F3Mul, 32'd9, 32'd9, 32'd81, 33, "mul_after_rst");

        // Start held through DONE, then a second DIV accepted in the following IDLE cycle.
        @(negedge clk);
        bus.start = 1'b1;
        bus.f3    = F3Div;
        bus.rs1   = 32'd100;
        bus.rs2   = 32'd7;
        d0        = done_pulses;
        wait_done(lat, stalls);
        check("b2b_first_result", bus.result, 32'd14);
        check("b2b_first_latency", lat, 32'd33);
        bus.f3  = F3Div;
        bus.rs1 = 32'hFFFF_FF9C;
        bus.rs2 = 32'd7;
        @(negedge clk);
        #1;
        check("b2b_no_retrigger_done", {31'b0, bus.done}, 32'd0);
        check("b2b_idle_busy", {31'b0, bus.busy}, 32'd0);
        check("b2b_idle_stall", {31'b0, bus.stall}, 32'd1);
        wait_done(lat, stalls);
        check("b2b_second_result", bus.result, 32'hFFFF_FFF2);
        check("b2b_second_latency", lat, 32'd33);
        bus.start = 1'b0;
        @(negedge clk);
        #1;
        check("b2b_done_count", done_pulses - d0, 32'd2);
        check("b2b_busy_after", {31'b0, bus.busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
